// File: rtl/tile_config_sequencer.sv
// Configuration bitstream sequencer: parses a header and (address, data) pairs from a
// valid/ready stream and presents each pair on the broadcast tile config bus.
module tile_config_sequencer #(
   parameter int unsigned HOLD_CYCLES = 1,
   parameter logic [15:0] MAGIC       = 16'hC0F1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [15:0] writes_done
);

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StAddr,
      StData,
      StIssue,
      StDone,
      StErr
   } state_t;

   localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

   state_t      state;
   logic [15:0] count_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [3:0]  hold_q;
   logic [15:0] wd_q;
   logic [1:0]  err_code_q;
   logic        mod_ok;

   // Only logic block, cb1, cb0 and switch box modules may be addressed.
   assign mod_ok = (in_data[31:16] >= 16'd4) && (in_data[31:16] <= 16'd7);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= StIdle;
         count_q    <= 16'd0;
         addr_q     <= 32'd0;
         data_q     <= 32'd0;
         hold_q     <= 4'd0;
         wd_q       <= 16'd0;
         err_code_q <= 2'd0;
      end else begin
         unique case (state)
            StIdle, StDone, StErr: begin
               if (start) begin
                  state      <= StHdr;
                  wd_q       <= 16'd0;
                  err_code_q <= 2'd0;
               end
            end
            StHdr: begin
               if (in_valid) begin
                  if (in_data[31:16] != MAGIC) begin
                     state      <= StErr;
                     err_code_q <= 2'd1;
                  end else begin
                     count_q <= in_data[15:0];
                     state   <= (in_data[15:0] == 16'd0) ? StDone : StAddr;
                  end
               end
            end
            StAddr: begin
               if (in_valid) begin
                  if (mod_ok) begin
                     addr_q <= in_data;
                     state  <= StData;
                  end else begin
                     state      <= StErr;
                     err_code_q <= 2'd2;
                  end
               end
            end
            StData: begin
               if (in_valid) begin
                  data_q <= in_data;
                  hold_q <= 4'd0;
                  state  <= StIssue;
               end
            end
            StIssue: begin
               if (hold_q == HoldLast) begin
                  hold_q <= 4'd0;
                  wd_q   <= wd_q + 16'd1;
                  state  <= (wd_q + 16'd1 == count_q) ? StDone : StAddr;
               end else begin
                  hold_q <= hold_q + 4'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      in_ready    = (state == StHdr) || (state == StAddr) || (state == StData);
      busy        = in_ready || (state == StIssue);
      done        = (state == StDone);
      error       = (state == StErr);
      // Module id 0 decodes nowhere, so a zero bus is idle.
      config_addr = (state == StIssue) ? addr_q : 32'd0;
      config_data = (state == StIssue) ? data_q : 32'd0;
      err_code    = err_code_q;
      writes_done = wd_q;
   end

endmodule

// File: tb/tb_tile_config_sequencer.sv
// Directed bench for tile_config_sequencer: per-cycle vector table on a HOLD_CYCLES=1
// instance, plus hand sequences on a HOLD_CYCLES=3 instance.
module tb_tile_config_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] in_data;
   logic        in_valid;

   logic        rdy1, busy1, done1, err1;
   logic [31:0] ca1, cd1;
   logic [1:0]  ec1;
   logic [15:0] wd1;
   logic        rdy3, busy3, done3, err3;
   logic [31:0] ca3, cd3;
   logic [1:0]  ec3;
   logic [15:0] wd3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tile_config_sequencer #(.HOLD_CYCLES(1), .MAGIC(16'hC0F1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .config_addr(ca1), .config_data(cd1), .busy(busy1), .done(done1),
      .error(err1), .err_code(ec1), .writes_done(wd1)
   );

   tile_config_sequencer #(.HOLD_CYCLES(3), .MAGIC(16'hC0F1)) dut3 (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy3), .config_addr(ca3), .config_data(cd3), .busy(busy3), .done(done3),
      .error(err3), .err_code(ec3), .writes_done(wd3)
   );

   typedef struct {
      logic        st;
      logic        vl;
      logic [31:0] dat;
      logic        rdy;
      logic [31:0] ca;
      logic [31:0] cd;
      logic        bsy;
      logic        dn;
      logic        er;
      logic [1:0]  ec;
      logic [15:0] wd;
   } vec_t;

   vec_t tbl[23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic vl, input logic [31:0] dat,
                               input logic rdy, input logic [31:0] ca, input logic [31:0] cd,
                               input logic bsy, input logic dn, input logic er,
                               input logic [1:0] ec, input logic [15:0] wd);
      vec_t v;
      v.st = st; v.vl = vl; v.dat = dat; v.rdy = rdy; v.ca = ca; v.cd = cd;
      v.bsy = bsy; v.dn = dn; v.er = er; v.ec = ec; v.wd = wd;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic drive(input logic st, input logic vl, input logic [31:0] dat);
      @(negedge clk);
      start = st; in_valid = vl; in_data = dat;
   endtask

   logic [31:0] words[3];
   int          ptr;
   int          issue_cyc;
   logic        fin;

   initial begin
      //          st vl dat            rdy ca            cd            bsy dn er ec wd
      tbl[0]  = mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 32'hC0F1_0002, 1, 32'h0,        32'h0,        1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 1, 32'h0004_0003, 1, 32'h0,        32'h0,        1, 0, 0, 0, 0);
      tbl[3]  = mk(0, 1, 32'h0000_0002, 1, 32'h0,        32'h0,        1, 0, 0, 0, 0);
      tbl[4]  = mk(0, 1, 32'h0007_0003, 0, 32'h0004_0003, 32'h0000_0002, 1, 0, 0, 0, 0);
      tbl[5]  = mk(0, 1, 32'h0007_0003, 1, 32'h0,        32'h0,        1, 0, 0, 0, 1);
      tbl[6]  = mk(0, 1, 32'hDEAD_BEEF, 1, 32'h0,        32'h0,        1, 0, 0, 0, 1);
      tbl[7]  = mk(0, 0, 32'h0,         0, 32'h0007_0003, 32'hDEAD_BEEF, 1, 0, 0, 0, 1);
      tbl[8]  = mk(0, 0, 32'h0,         0, 32'h0,        32'h0,        0, 1, 0, 0, 2);
      tbl[9]  = mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 1, 0, 0, 2);
      tbl[10] = mk(0, 1, 32'hBEEF_0001, 1, 32'h0,        32'h0,        1, 0, 0, 0, 0);
      tbl[11] = mk(0, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 1, 1, 0);
      tbl[12] = mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 1, 1, 0);
      tbl[13] = mk(0, 1, 32'hC0F1_0000, 1, 32'h0,        32'h0,        1, 0, 0, 0, 0);
      tbl[14] = mk(0, 0, 32'h0,         0, 32'h0,        32'h0,        0, 1, 0, 0, 0);
      tbl[15] = mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 1, 0, 0, 0);
      tbl[16] = mk(0, 1, 32'hC0F1_0002, 1, 32'h0,        32'h0,        1, 0, 0, 0, 0);
      // start alongside an ADDR transfer must be ignored
      tbl[17] = mk(1, 1, 32'h0005_0001, 1, 32'h0,        32'h0,        1, 0, 0, 0, 0);
      tbl[18] = mk(0, 1, 32'h1111_2222, 1, 32'h0,        32'h0,        1, 0, 0, 0, 0);
      tbl[19] = mk(0, 1, 32'h0009_0000, 0, 32'h0005_0001, 32'h1111_2222, 1, 0, 0, 0, 0);
      tbl[20] = mk(0, 1, 32'h0009_0000, 1, 32'h0,        32'h0,        1, 0, 0, 0, 1);
      tbl[21] = mk(0, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 1, 2, 1);
      tbl[22] = mk(0, 1, 32'h0009_0000, 0, 32'h0,        32'h0,        0, 0, 1, 2, 1);

      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
      #3;
      chk("reset ready", {31'd0, rdy1}, 32'd0);
      chk("reset busy", {31'd0, busy1}, 32'd0);
      chk("reset addr", ca1, 32'd0);
      chk("reset wd", {16'd0, wd1}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 23; i++) begin
         drive(tbl[i].st, tbl[i].vl, tbl[i].dat);
         #1;
         chk($sformatf("row%0d ready", i), {31'd0, rdy1}, {31'd0, tbl[i].rdy});
         chk($sformatf("row%0d addr", i), ca1, tbl[i].ca);
         chk($sformatf("row%0d data", i), cd1, tbl[i].cd);
         chk($sformatf("row%0d busy", i), {31'd0, busy1}, {31'd0, tbl[i].bsy});
         chk($sformatf("row%0d done", i), {31'd0, done1}, {31'd0, tbl[i].dn});
         chk($sformatf("row%0d error", i), {31'd0, err1}, {31'd0, tbl[i].er});
         chk($sformatf("row%0d err_code", i), {30'd0, ec1}, {30'd0, tbl[i].ec});
         chk($sformatf("row%0d writes", i), {16'd0, wd1}, {16'd0, tbl[i].wd});
      end

      // HOLD_CYCLES=3, in_valid toggling every other cycle
      do_reset();
      words[0] = 32'hC0F1_0001; words[1] = 32'h0006_0005; words[2] = 32'hCAFE_F00D;
      ptr = 0; issue_cyc = 0; fin = 1'b0;
      drive(1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 40 && !fin; i++) begin
         @(negedge clk);
         start    = 1'b0;
         in_valid = (i % 2) == 1;
         in_data  = (ptr < 3) ? words[ptr] : 32'd0;
         #1;
         if (ca3 != 32'd0) begin
            issue_cyc++;
            chk("hold3 addr", ca3, 32'h0006_0005);
            chk("hold3 data", cd3, 32'hCAFE_F00D);
            chk("hold3 ready low", {31'd0, rdy3}, 32'd0);
         end
         if (in_valid && rdy3) ptr++;
         if (done3) fin = 1'b1;
      end
      chk("hold3 finished", {31'd0, fin}, 32'd1);
      chk("hold3 issue cycles", issue_cyc, 3);
      chk("hold3 words taken", ptr, 3);
      chk("hold3 writes", {16'd0, wd3}, 32'd1);

      // Reset during the second ISSUE cycle
      do_reset();
      drive(1'b1, 1'b0, 32'd0);
      drive(1'b0, 1'b1, 32'hC0F1_0001);
      drive(1'b0, 1'b1, 32'h0004_0001);
      drive(1'b0, 1'b1, 32'h0000_0055);
      drive(1'b0, 1'b0, 32'd0);
      #1;
      chk("rst issue1 addr", ca3, 32'h0004_0001);
      drive(1'b0, 1'b0, 32'd0);
      #1;
      chk("rst issue2 data", cd3, 32'h0000_0055);
      reset = 1'b0;
      #1;
      chk("rst addr zero", ca3, 32'd0);
      chk("rst data zero", cd3, 32'd0);
      chk("rst busy zero", {31'd0, busy3}, 32'd0);
      chk("rst flags zero", {28'd0, ready_flags()}, 32'd0);
      chk("rst writes zero", {16'd0, wd3}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 1'b0, 32'd0);
      drive(1'b0, 1'b1, 32'hC0F1_0001);
      drive(1'b0, 1'b1, 32'h0007_0002);
      drive(1'b0, 1'b1, 32'h1234_5678);
      fin = 1'b0;
      for (int i = 0; i < 12 && !fin; i++) begin
         drive(1'b0, 1'b0, 32'd0);
         #1;
         if (done3) fin = 1'b1;
      end
      chk("reload done", {31'd0, fin}, 32'd1);
      chk("reload writes", {16'd0, wd3}, 32'd1);
      chk("reload no error", {30'd0, err3, ec3 != 2'd0}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic logic [3:0] ready_flags();
      return {rdy3, done3, err3, |ec3};
   endfunction

endmodule
